// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared FSM state encoding and port IDs for ram_arbiter
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic PORT_ADMA = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rtl/ram_arbiter_rr_picker.sv - 2-way winner picker; RAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module ram_arbiter_rr_picker
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Contested: the port that did not win last time; otherwise the lone requester.
  always_comb begin
    winner = PORT_ADMA;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = PORT_HOST;
    end
  end
`else
  // Fixed priority: the host only wins when the ADMA engine is not asking.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = PORT_ADMA;
    if (!req[0] && req[1]) begin
      winner = PORT_HOST;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port word access arbiter in front of the shared RAM; RAM_ARB_ROUND_ROBIN_EN enables round-robin
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_BYTES - 4);

  arb_state_t        state, state_next;
  logic              win_q, write_q, err_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        req;
  logic              winner;
  logic              sel_write, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {m1_req, m0_req};

  ram_arbiter_rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  assign sel_write = (winner == PORT_HOST) ? m1_write : m0_write;
  assign sel_addr  = (winner == PORT_HOST) ? m1_addr  : m0_addr;
  assign sel_wdata = (winner == PORT_HOST) ? m1_wdata : m0_wdata;
  // Unsigned compare over the full address width, so anything at or above 2^32 is rejected too.
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_MAX);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winning command in IDLE; remember who was served once the response goes out.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      win_q        <= PORT_ADMA;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= PORT_HOST;
    end else begin
      if (state == ST_IDLE && req != 2'b00) begin
        win_q   <= winner;
        write_q <= sel_write;
        err_q   <= sel_err;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == ST_RESP) begin
        last_grant_q <= win_q;
      end
    end
  end

  // Next state plus grant, RAM strobe and response decode.
  always_comb begin
    state_next  = state;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    ram_write   = 1'b0;
    ram_read    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m0_gnt = (win_q == PORT_ADMA);
        m1_gnt = (win_q == PORT_HOST);
        if (!err_q) begin
          ram_address = addr_q;
          ram_write   = write_q;
          ram_read    = !write_q;
          if (write_q) begin
            ram_data_in = wdata_q;
          end
        end
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (win_q == PORT_ADMA) begin
          m0_rvalid = 1'b1;
          m0_err    = err_q;
          m0_rdata  = (!write_q && !err_q) ? ram_data_out : '0;
        end else begin
          m1_rvalid = 1'b1;
          m1_err    = err_q;
          m1_rdata  = (!write_q && !err_q) ? ram_data_out : '0;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized bench for ram_arbiter against a transaction-level schedule model
module tb_ram_arbiter;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 32;
  localparam int MEM_BYTES = 128;
  localparam int WORDS     = MEM_BYTES / 4;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  logic              ram_write, ram_read;

  logic [DATA_W-1:0] ram_mem [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];

  int vectors = 0;
  int miscompares = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .RESET(RESET),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write(ram_write), .ram_read(ram_read), .ram_data_out(ram_data_out)
  );

  always #5 CLK = ~CLK;

  // Single-ported RAM: captures data_out at the end of the strobe cycle.
  always @(posedge CLK) begin
    if (ram_write) ram_mem[ram_address[6:2]] <= ram_data_in;
    if (ram_read)  ram_data_out <= ram_mem[ram_address[6:2]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one access scheduled at a time, contest at most every 3 cycles.
  int                cyc = 0;
  int                next_free = 0;
  bit                sched = 1'b0;
  int                gnt_cyc = 0;
  bit                due_port, due_write, due_err;
  logic [ADDR_W-1:0] due_addr;
  logic [DATA_W-1:0] due_wdata, due_rdata;
  bit                last_g = 1'b1;
  bit                prev_req [2];
  int                req_start [2];

  initial begin
    logic [1:0] exp_gnt, exp_rv, exp_strb;
    logic [63:0] exp_rsp0, exp_rsp1;
    bit issue_now, resp_now, both, w, gnt_p0, gnt_p1, r;
    int wait_c, limit;
    logic [ADDR_W-1:0] a;
    prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    req_start[0] = 0; req_start[1] = 0;
    forever begin
      @(negedge CLK);
      issue_now = sched && (gnt_cyc == cyc);
      resp_now  = sched && (gnt_cyc + 1 == cyc);
      exp_gnt  = issue_now ? (due_port ? 2'b10 : 2'b01) : 2'b00;
      exp_rv   = resp_now  ? (due_port ? 2'b10 : 2'b01) : 2'b00;
      exp_strb = (issue_now && !due_err) ? (due_write ? 2'b10 : 2'b01) : 2'b00;
      exp_rsp0 = (resp_now && !due_port) ? {31'b0, due_err, due_rdata} : 64'h0;
      exp_rsp1 = (resp_now &&  due_port) ? {31'b0, due_err, due_rdata} : 64'h0;
      check("gnt",       64'({m1_gnt, m0_gnt}), 64'(exp_gnt));
      check("rvalid",    64'({m1_rvalid, m0_rvalid}), 64'(exp_rv));
      check("strobe",    64'({ram_write, ram_read}), 64'(exp_strb));
      check("ram_addr",  ram_address, (issue_now && !due_err) ? due_addr : 64'h0);
      check("ram_wdata", 64'(ram_data_in), (issue_now && !due_err && due_write) ? 64'(due_wdata) : 64'h0);
      check("m0_resp",   {31'b0, m0_err, m0_rdata}, exp_rsp0);
      check("m1_resp",   {31'b0, m1_err, m1_rdata}, exp_rsp1);
      gnt_p0 = issue_now && !due_port;
      gnt_p1 = issue_now &&  due_port;
      if (resp_now) begin
        last_g = due_port;
        sched  = 1'b0;
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? m0_req : m1_req;
        if (r && (!prev_req[p] || (p == 0 ? gnt_p0 : gnt_p1))) req_start[p] = cyc;
        prev_req[p] = r;
      end
      if (RESET) begin
        sched     = 1'b0;
        last_g    = 1'b1;
        next_free = cyc + 1;
      end else if (cyc >= next_free && (m0_req || m1_req)) begin
        both = m0_req && m1_req;
        w    = both ? (RR ? !last_g : 1'b0) : m1_req;
        a    = w ? m1_addr : m0_addr;
        due_port  = w;
        due_write = w ? m1_write : m0_write;
        due_wdata = w ? m1_wdata : m0_wdata;
        due_addr  = a;
        due_err   = (a % 4 != 0) || (a > 64'(MEM_BYTES - 4));
        due_rdata = (!due_write && !due_err) ? ref_mem[a[6:2]] : 32'h0;
        if (due_write && !due_err) ref_mem[a[6:2]] = due_wdata;
        wait_c = cyc + 1 - req_start[w];
        limit  = (RR || !w) ? 6 : 1000000;
        check("wait_bound", 64'(wait_c <= limit), 64'h1);
        sched     = 1'b1;
        gnt_cyc   = cyc + 1;
        next_free = cyc + 3;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(negedge CLK);
    if (m0_gnt) m0_req = 1'b0;
    if (m1_gnt) m1_req = 1'b0;
  endtask

  task automatic issue(input bit p, input bit w, input logic [63:0] a, input logic [31:0] d);
    if (!p) begin
      m0_req = 1'b1; m0_write = w; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = 1'b1; m1_write = w; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m0_req || m1_req) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(m0_req || m1_req), 64'h0);
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 64'(MEM_BYTES);
      1:       return 64'h1_0000_0000 + 64'($urandom_range(0, 3) * 4);
      2:       return {32'($urandom), 32'($urandom)};
      3:       return 64'($urandom_range(0, MEM_BYTES - 1));
      4:       return 64'(MEM_BYTES - 4);
      default: return 64'($urandom_range(0, WORDS - 1) * 4);
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] = 32'hA5000000 + 32'(i * 3);
      ref_mem[i] = 32'hA5000000 + 32'(i * 3);
    end
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;

    issue(1'b0, 1'b1, 64'd8, 32'hDEADBEEF);            wait_idle(20);
    issue(1'b0, 1'b0, 64'd8, 32'h0);                   wait_idle(20);
    issue(1'b1, 1'b0, 64'd6, 32'h0);                   wait_idle(20);
    issue(1'b1, 1'b0, 64'd128, 32'h0);                 wait_idle(20);
    issue(1'b1, 1'b0, 64'd124, 32'h0);                 wait_idle(20);
    issue(1'b0, 1'b1, 64'h1_0000_0000, 32'h12345678);  wait_idle(20);
    issue(1'b0, 1'b0, 64'd0, 32'h0);                   wait_idle(20);

    // Reset lands during ISSUE of a host read.
    issue(1'b1, 1'b0, 64'd16, 32'h0);
    n = 0;
    while (m1_req && n < 20) begin tick(); n++; end
    check("reset_gnt_timeout", 64'(m1_req), 64'h0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    issue(1'b0, 1'b0, 64'd20, 32'h0);
    issue(1'b1, 1'b0, 64'd24, 32'h0);
    wait_idle(40);

    // Host request raised during the ADMA response cycle.
    issue(1'b0, 1'b0, 64'd4, 32'h0);
    n = 0;
    while (m0_req && n < 20) begin tick(); n++; end
    tick();
    issue(1'b1, 1'b0, 64'd12, 32'h0);
    wait_idle(20);

    // Both ports saturated.
    repeat (240) begin
      tick();
      if (!m0_req) issue(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!m1_req) issue(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    tick();
    m1_req = 1'b0;
    wait_idle(20);
    m1_req = 1'b0;

    // Sparse random traffic.
    repeat (400) begin
      tick();
      if (!m0_req && $urandom_range(0, 3) == 0) issue(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!m1_req && $urandom_range(0, 3) == 0) issue(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    m1_req = m1_req && RR;
    wait_idle(60);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
